// File: rtl/coin_acceptor.sv
// Coin sensor front end: debounces raw sensor levels, queues rising-edge coin
// events and emits paced one-hot pulses toward vending_machine.
module coin_acceptor #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int FIFO_DEPTH      = 4,
   parameter int GAP_CYCLES      = 1
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic [2:0]                         i_coin_sense,
   input  logic                               i_inhibit,
   output logic [2:0]                         o_input_coin,
   output logic [2:0]                         o_reject,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]    o_fifo_count,
   output logic [2:0]                         o_pending
);
   localparam int DW = $clog2(DEBOUNCE_CYCLES);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);
   localparam logic [CW-1:0] FIFO_FULL = CW'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EMIT = 2'd1,
      ST_GAP  = 2'd2
   } state_t;

   function automatic logic [2:0] code_to_onehot(input logic [1:0] code);
      logic [2:0] oh;
      case (code)
         2'd0:    oh = 3'b001;
         2'd1:    oh = 3'b010;
         2'd2:    oh = 3'b100;
         default: oh = 3'b000;
      endcase
      return oh;
   endfunction

   logic [2:0]    s_raw_r;
   logic [2:0]    stable_r;
   logic [2:0]    stable_d_r;
   logic [DW-1:0] deb_cnt_r [3];
   logic [2:0]    pending_r;
   logic [2:0]    reject_r;
   logic [2:0]    coin_r;
   logic [1:0]    fifo_mem_r [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr_r;
   logic [PW-1:0] rd_ptr_r;
   logic [CW-1:0] count_r;
   state_t        state_r;
   logic [GW-1:0] gap_cnt_r;

   logic [2:0]    rise_s;
   logic [2:0]    clear_s;
   logic [2:0]    reject_s;
   logic [2:0]    pending_next_s;
   logic          push_s;
   logic [1:0]    push_code_s;
   logic          pop_s;
   logic [1:0]    head_s;

   // Sample raw sensors and debounce each channel into a stable level
   always_ff @(posedge clk) begin
      if (reset) begin
         s_raw_r    <= 3'b111;
         stable_r   <= 3'b111;
         stable_d_r <= 3'b111;
         for (int i = 0; i < 3; i++) begin
            deb_cnt_r[i] <= {DW{1'b0}};
         end
      end else begin
         s_raw_r    <= i_coin_sense;
         stable_d_r <= stable_r;
         for (int i = 0; i < 3; i++) begin
            if (s_raw_r[i] != stable_r[i]) begin
               if (deb_cnt_r[i] == DEB_LAST) begin
                  stable_r[i]  <= s_raw_r[i];
                  deb_cnt_r[i] <= {DW{1'b0}};
               end else begin
                  deb_cnt_r[i] <= deb_cnt_r[i] + DW'(1);
               end
            end else begin
               deb_cnt_r[i] <= {DW{1'b0}};
            end
         end
      end
   end

   // Event detection, lowest-index arbitration into the FIFO, reject on collision
   always_comb begin
      rise_s      = stable_r & ~stable_d_r;
      push_s      = 1'b0;
      push_code_s = 2'd0;
      clear_s     = 3'b000;
      if (count_r != FIFO_FULL) begin
         if (pending_r[0]) begin
            push_s      = 1'b1;
            push_code_s = 2'd0;
            clear_s     = 3'b001;
         end else if (pending_r[1]) begin
            push_s      = 1'b1;
            push_code_s = 2'd1;
            clear_s     = 3'b010;
         end else if (pending_r[2]) begin
            push_s      = 1'b1;
            push_code_s = 2'd2;
            clear_s     = 3'b100;
         end else begin
            push_s      = 1'b0;
         end
      end else begin
         push_s = 1'b0;
      end
      reject_s       = rise_s & pending_r & ~clear_s;
      pending_next_s = (pending_r & ~clear_s) | rise_s;
      head_s         = fifo_mem_r[rd_ptr_r];
      pop_s          = (state_r == ST_IDLE) && (count_r != {CW{1'b0}}) && !i_inhibit;
   end

   // Pending bits and reject pulses
   always_ff @(posedge clk) begin
      if (reset) begin
         pending_r <= 3'b000;
         reject_r  <= 3'b000;
      end else begin
         pending_r <= pending_next_s;
         reject_r  <= reject_s;
      end
   end

   // Coin queue storage, pointers and occupancy
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_r <= {PW{1'b0}};
         rd_ptr_r <= {PW{1'b0}};
         count_r  <= {CW{1'b0}};
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_mem_r[i] <= 2'd0;
         end
      end else begin
         if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= push_code_s;
            wr_ptr_r             <= wr_ptr_r + PW'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PW'(1);
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + CW'(1);
            2'b01:   count_r <= count_r - CW'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Output pacing FSM; inhibit only gates the start of a pulse
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r   <= ST_IDLE;
         gap_cnt_r <= {GW{1'b0}};
         coin_r    <= 3'b000;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (pop_s) begin
                  state_r <= ST_EMIT;
                  coin_r  <= code_to_onehot(head_s);
               end else begin
                  coin_r  <= 3'b000;
               end
            end
            ST_EMIT: begin
               state_r   <= ST_GAP;
               gap_cnt_r <= {GW{1'b0}};
               coin_r    <= 3'b000;
            end
            ST_GAP: begin
               coin_r <= 3'b000;
               if (gap_cnt_r == GAP_LAST) begin
                  state_r <= ST_IDLE;
               end else begin
                  gap_cnt_r <= gap_cnt_r + GW'(1);
               end
            end
            default: begin
               state_r <= ST_IDLE;
               coin_r  <= 3'b000;
            end
         endcase
      end
   end

   assign o_input_coin = coin_r;
   assign o_reject     = reject_r;
   assign o_fifo_count = count_r;
   assign o_pending    = pending_r;

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed bench for coin_acceptor: a cycle-exact vector table for reset and a
// clean coin, plus hand sequences for bounce, arbitration, backpressure, inhibit, reset.
module tb_coin_acceptor;
   logic       clk = 1'b0;
   logic       reset;
   logic [2:0] coin_sense;
   logic       inhibit;
   logic [2:0] o_input_coin;
   logic [2:0] o_reject;
   logic [2:0] o_fifo_count;
   logic [2:0] o_pending;

   int n_vec = 0;
   int n_bad = 0;

   logic [2:0] pulse_q [$];
   logic [2:0] reject_q [$];
   logic [2:0] prev_coin = 3'b000;

   typedef struct {
      logic       rst;
      logic [2:0] sense;
      logic       inh;
      logic [2:0] coin;
      logic [2:0] rej;
      logic [2:0] cnt;
      logic [2:0] pend;
   } vec_t;

   vec_t tbl [$];

   coin_acceptor #(.DEBOUNCE_CYCLES(4), .FIFO_DEPTH(4), .GAP_CYCLES(1)) dut (
      .clk          (clk),
      .reset        (reset),
      .i_coin_sense (coin_sense),
      .i_inhibit    (inhibit),
      .o_input_coin (o_input_coin),
      .o_reject     (o_reject),
      .o_fifo_count (o_fifo_count),
      .o_pending    (o_pending)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(input logic r, input logic [2:0] s, input logic [2:0] c,
                               input logic [2:0] cnt, input logic [2:0] p);
      vec_t v;
      v.rst = r; v.sense = s; v.inh = 1'b0;
      v.coin = c; v.rej = 3'b000; v.cnt = cnt; v.pend = p;
      return v;
   endfunction

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // One clock: drive inputs, sample 1 time unit after the edge, log pulses
   task automatic step(input logic r, input logic [2:0] s, input logic inh);
      reset = r; coin_sense = s; inhibit = inh;
      @(posedge clk);
      #1;
      if (o_input_coin !== 3'b000) begin
         pulse_q.push_back(o_input_coin);
         n_vec++;
         if (!$onehot(o_input_coin) || prev_coin !== 3'b000) begin
            n_bad++;
            $display("FAIL pulse_shape: got %b after %b, expected one-hot after zero",
                     o_input_coin, prev_coin);
         end
      end
      if (o_reject !== 3'b000) reject_q.push_back(o_reject);
      prev_coin = o_input_coin;
   endtask

   task automatic coin(input logic [2:0] s, input int hi, input int lo, input logic inh);
      for (int k = 0; k < hi; k++) step(1'b0, s, inh);
      for (int k = 0; k < lo; k++) step(1'b0, 3'b000, inh);
   endtask

   task automatic clear_logs();
      pulse_q.delete();
      reject_q.delete();
   endtask

   initial begin
      reset = 1'b1; coin_sense = 3'b000; inhibit = 1'b0;

      // Reset, re-arm, then a clean 500 coin: pulse 7 edges after E0
      tbl.push_back(mk(1'b1, 3'b000, 3'b000, 3'd0, 3'b000));
      for (int k = 0; k < 6; k++) tbl.push_back(mk(1'b0, 3'b000, 3'b000, 3'd0, 3'b000));
      for (int t = 0; t < 16; t++) begin
         logic [2:0] s;
         logic [2:0] c;
         logic [2:0] cnt;
         logic [2:0] p;
         s   = (t < 10) ? 3'b010 : 3'b000;
         c   = (t == 7) ? 3'b010 : 3'b000;
         cnt = (t == 6) ? 3'd1 : 3'd0;
         p   = (t == 5) ? 3'b010 : 3'b000;
         tbl.push_back(mk(1'b0, s, c, cnt, p));
      end
      for (int i = 0; i < tbl.size(); i++) begin
         step(tbl[i].rst, tbl[i].sense, tbl[i].inh);
         chk($sformatf("vec%0d", i),
             {4'h0, o_input_coin, o_reject, o_fifo_count, o_pending},
             {4'h0, tbl[i].coin, tbl[i].rej, tbl[i].cnt, tbl[i].pend});
      end

      // Bounce 1,0,1,0 then steady high: exactly one 100 pulse
      clear_logs();
      coin(3'b001, 1, 1, 1'b0);
      coin(3'b001, 1, 1, 1'b0);
      coin(3'b001, 8, 14, 1'b0);
      chk("bounce_npulse", 16'(pulse_q.size()), 16'd1);
      if (pulse_q.size() > 0) chk("bounce_value", {13'd0, pulse_q[0]}, 16'h0001);
      chk("bounce_nreject", 16'(reject_q.size()), 16'd0);

      // Short glitch: nothing at all
      clear_logs();
      coin(3'b001, 3, 20, 1'b0);
      chk("glitch_npulse", 16'(pulse_q.size()), 16'd0);
      chk("glitch_nreject_pend", {13'd0, o_pending} | 16'(reject_q.size()), 16'd0);

      // Simultaneous rise: drained 100, 500, 1000
      clear_logs();
      for (int k = 0; k < 28; k++) begin
         step(1'b0, (k < 8) ? 3'b111 : 3'b000, 1'b0);
         if (k == 5) chk("simul_pending", {13'd0, o_pending}, 16'h0007);
         if (k == 6) chk("simul_drain1", {10'd0, o_fifo_count, o_pending}, {10'd0, 3'd1, 3'b110});
      end
      chk("simul_npulse", 16'(pulse_q.size()), 16'd3);
      if (pulse_q.size() == 3)
         chk("simul_order", {7'd0, pulse_q[0], pulse_q[1], pulse_q[2]},
             {7'd0, 3'b001, 3'b010, 3'b100});

      // Backpressure: six coins while inhibited, then release
      clear_logs();
      for (int n = 0; n < 6; n++) coin(3'b001, 6, 8, 1'b1);
      chk("bp_count", {13'd0, o_fifo_count}, 16'd4);
      chk("bp_pending", {13'd0, o_pending}, 16'h0001);
      chk("bp_nreject", 16'(reject_q.size()), 16'd1);
      if (reject_q.size() > 0) chk("bp_reject_ch", {13'd0, reject_q[0]}, 16'h0001);
      chk("bp_no_pulse", 16'(pulse_q.size()), 16'd0);
      for (int k = 0; k < 40; k++) step(1'b0, 3'b000, 1'b0);
      chk("bp_npulse", 16'(pulse_q.size()), 16'd5);
      for (int i = 0; i < pulse_q.size(); i++)
         chk($sformatf("bp_pulse%0d", i), {13'd0, pulse_q[i]}, 16'h0001);
      chk("bp_drained", {10'd0, o_fifo_count, o_pending}, 16'd0);

      // Inhibit raised while the first pulse is on the bus
      clear_logs();
      for (int k = 0; k < 20 && pulse_q.size() == 0; k++)
         step(1'b0, (k < 8) ? 3'b011 : 3'b000, 1'b0);
      chk("inh_first", {13'd0, o_input_coin}, 16'h0001);
      for (int k = 0; k < 12; k++) step(1'b0, 3'b000, 1'b1);
      chk("inh_withheld", 16'(pulse_q.size()), 16'd1);
      chk("inh_queued", {13'd0, o_fifo_count}, 16'd1);
      for (int k = 0; k < 10 && pulse_q.size() < 2; k++) step(1'b0, 3'b000, 1'b0);
      chk("inh_resume_n", 16'(pulse_q.size()), 16'd2);
      if (pulse_q.size() == 2) chk("inh_resume_val", {13'd0, pulse_q[1]}, 16'h0002);

      // Reset with two coins queued and the 1000 sensor held high
      clear_logs();
      coin(3'b011, 6, 8, 1'b1);
      chk("rst_queued", {13'd0, o_fifo_count}, 16'd2);
      step(1'b1, 3'b100, 1'b1);
      chk("rst_outputs", {4'h0, o_input_coin, o_reject, o_fifo_count, o_pending}, 16'd0);
      for (int k = 0; k < 20; k++) step(1'b0, 3'b100, 1'b0);
      chk("rst_held_nopulse", {10'd0, o_fifo_count, o_pending} | 16'(pulse_q.size()), 16'd0);
      for (int k = 0; k < 8; k++) step(1'b0, 3'b000, 1'b0);
      coin(3'b100, 6, 16, 1'b0);
      chk("rst_new_n", 16'(pulse_q.size()), 16'd1);
      if (pulse_q.size() > 0) chk("rst_new_val", {13'd0, pulse_q[0]}, 16'h0004);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
